axis_frame_tx: RTL

- AXI-Stream frame transmitter that produces the input frame format consumed by the matrix-transform `top` block.
- Frame format:
  - MAT_ROWS matrix beats first, each carrying one row of LANES q16 coefficients.
  - VEC_BEATS vector beats follow, each carrying LANES q16 values.
  - tlast is asserted on the final vector beat.
- Coefficients are loaded through a simple write port. Vectors arrive on a slave stream and are buffered in an internal FIFO.
- Sits upstream of `top` on the same clock.

---
 rtl/axis_frame_tx_if.sv | 14 +
 rtl/axis_frame_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_frame_tx_if.sv
// AXI-Stream beat bundle shared by the frame transmitter's input and output streams.
// tlast is only meaningful on the master side; the slave side does not consume it.
interface axis_frame_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
) ();
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_frame_tx.sv
// Frame transmitter: MAT_ROWS coefficient beats from a small RAM, then VEC_BEATS
// vector beats drained from a FIFO, tlast on the final vector beat.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int MAT_ROWS   = 3,
  parameter int VEC_BEATS  = 12,
  parameter int FIFO_DEPTH = 16,
  localparam int NCOEF     = MAT_ROWS * LANES,
  localparam int ADDR_W    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  coef_wr_en,
  input  logic [ADDR_W-1:0]     coef_wr_addr,
  input  logic [DATA_WIDTH-1:0] coef_wr_data,
  input  logic                  start,
  axis_frame_tx_if.slave        s00_axis,
  axis_frame_tx_if.master       m00_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  coef_wr_err
);
  localparam int BEAT_W = LANES * DATA_WIDTH;
  localparam int ROW_W  = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1;
  localparam int VCNT_W = $clog2(VEC_BEATS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] NCOEF_V = (ADDR_W + 1)'(NCOEF);

  typedef enum logic [1:0] {IDLE, MAT, VEC, LAST_WAIT} state_t;

  state_t state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, vcnt_base;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [BEAT_W-1:0] tdata_q, tdata_d;
  logic              hs, vec_try;

  assign busy = (state_q == MAT) || (state_q == VEC);
  assign done = (state_q == LAST_WAIT);

  // ---------------- coefficient RAM ----------------
  logic [NCOEF-1:0][DATA_WIDTH-1:0] coef_q;
  logic [MAT_ROWS-1:0][BEAT_W-1:0]  coef_row;

  for (genvar r = 0; r < MAT_ROWS; r++) begin : g_row
    assign coef_row[r] = coef_q[r*LANES +: LANES];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      coef_q      <= '0;
      coef_wr_err <= 1'b0;
    end else if (coef_wr_en) begin
      if (busy)
        coef_wr_err <= 1'b1;
      else if ({1'b0, coef_wr_addr} < NCOEF_V)
        coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

  // ---------------- vector FIFO ----------------
  logic [BEAT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              s_ready, push, pop, fifo_empty;

  assign s_ready         = (fifo_cnt != (PTR_W + 1)'(FIFO_DEPTH));
  assign s00_axis.tready = s_ready;
  assign push            = s00_axis.tvalid && s_ready;
  assign fifo_empty      = (fifo_cnt == '0);

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= s00_axis.tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- frame FSM and output register ----------------
  assign hs = tvalid_q && m00_axis.tready;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    vcnt_d    = vcnt_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    vcnt_base = vcnt_q;
    vec_try   = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = MAT;
        row_d    = '0;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tdata_d  = coef_row[0];
      end
      MAT: if (hs) begin
        if (row_q == ROW_W'(MAT_ROWS - 1)) begin
          // last row leaves; try to load vector 0 in the same edge for full throughput
          state_d   = VEC;
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          vcnt_d    = '0;
          vcnt_base = '0;
          vec_try   = 1'b1;
        end else begin
          row_d   = row_q + 1'b1;
          tdata_d = coef_row[row_q + 1'b1];
        end
      end
      VEC: if (hs && tlast_q) begin
        state_d  = LAST_WAIT;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end else begin
        if (hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        // vcnt counts beats loaded, so nothing is popped once the tlast beat is held
        vec_try = (!tvalid_q || hs) && (vcnt_q != VCNT_W'(VEC_BEATS));
      end
      LAST_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (vec_try && !fifo_empty) begin
      pop      = 1'b1;
      tvalid_d = 1'b1;
      tdata_d  = fifo_mem[rd_ptr];
      tlast_d  = (vcnt_base == VCNT_W'(VEC_BEATS - 1));
      vcnt_d   = vcnt_base + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      vcnt_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      vcnt_q   <= vcnt_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tlast  = tlast_q;
  assign m00_axis.tdata  = tdata_q;
endmodule
